bus_line_fill: RTL and testbench

- Per-requestor read engine between a pipeline stage (fetch or mm) and the shared Sysbus.
- Takes a 64-bit physical address and wins the shared bus through the codebase's six-way bus arbiter (reqcyc/grant/busy triplet).
- Issues one read request, collects eight 64-bit response beats and presents a 512-bit line to the stage.
- Fetch and mm instantiate one each: fetch for instruction lines, mm for load data.

---
 rtl/bus_line_fill.sv | 152 +++++++++++++++
 tb/tb_bus_line_fill.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_line_fill.sv
// Line-fill read engine: arbitrates for the shared Sysbus, issues one read,
// gathers BEATS response beats and presents the assembled line to its stage.
module bus_line_fill #(
  parameter int                   BUS_DATA_WIDTH = 64,
  parameter int                   BUS_TAG_WIDTH  = 13,
  parameter int                   ADDRESS_WIDTH  = 64,
  parameter int                   BEATS          = 8,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG   = 13'h1100
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]            in_req_addr,
  output logic                                out_req_ready,
  input  logic                                in_flush,
  output logic                                out_line_valid,
  output logic [BUS_DATA_WIDTH*BEATS-1:0]     out_line,
  output logic [ADDRESS_WIDTH-1:0]            out_line_addr,
  output logic                                out_abtr_reqcyc,
  input  logic                                in_abtr_grant,
  output logic                                out_bus_busy,
  output logic                                out_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]           out_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]            out_bus_reqtag,
  input  logic                                in_bus_reqack,
  input  logic                                in_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]           in_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]            in_bus_resptag,
  output logic                                out_bus_respack
);

  localparam int LINE_W   = BUS_DATA_WIDTH * BEATS;
  localparam int OFF_BITS = $clog2(LINE_W / 8);
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    REQ  = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                    state_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      drop_r;
  logic [ADDRESS_WIDTH-1:0]  addr_r;
  logic [LINE_W-1:0]         buf_r;
  logic [LINE_W-1:0]         buf_next_s;
  logic                      last_beat_s;
  logic [BUS_TAG_WIDTH-1:0]  resptag_unused_s;

  // Response tags are not checked; only one read is ever outstanding.
  assign resptag_unused_s = in_bus_resptag;

  // Staging buffer with the current beat merged into its slot.
  always_comb begin
    buf_next_s = buf_r;
    buf_next_s[int'(cnt_r)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = in_bus_resp;
  end

  assign last_beat_s = in_bus_respcyc && (cnt_r == CNT_W'(BEATS - 1));

  assign out_req_ready   = (state_r == IDLE);
  assign out_abtr_reqcyc = (state_r == ARB);
  assign out_bus_busy    = (state_r == REQ) || (state_r == RESP);
  assign out_bus_reqcyc  = (state_r == REQ);
  assign out_bus_req     = (state_r == REQ) ? BUS_DATA_WIDTH'(addr_r) : {BUS_DATA_WIDTH{1'b0}};
  assign out_bus_reqtag  = (state_r == REQ) ? READ_TAG : {BUS_TAG_WIDTH{1'b0}};
  assign out_bus_respack = (state_r == RESP) && in_bus_respcyc;
  assign out_line_valid  = (state_r == DONE) && !in_flush;

  // Fill sequencer; beats land in buf_r so a dropped fill never disturbs out_line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      drop_r        <= 1'b0;
      addr_r        <= {ADDRESS_WIDTH{1'b0}};
      buf_r         <= {LINE_W{1'b0}};
      out_line      <= {LINE_W{1'b0}};
      out_line_addr <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          drop_r <= 1'b0;
          if (in_req_valid && !in_flush) begin
            addr_r  <= {in_req_addr[ADDRESS_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            state_r <= ARB;
          end else begin
            state_r <= IDLE;
          end
        end
        ARB: begin
          if (in_flush) begin
            state_r <= IDLE;
          end else if (in_abtr_grant) begin
            state_r <= REQ;
          end else begin
            state_r <= ARB;
          end
        end
        REQ: begin
          // Once the bus is ours the transaction runs to completion; a flush only marks it.
          if (in_flush) begin
            drop_r <= 1'b1;
          end else begin
            drop_r <= drop_r;
          end
          if (in_bus_reqack) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= RESP;
          end else begin
            state_r <= REQ;
          end
        end
        RESP: begin
          if (in_bus_respcyc) begin
            buf_r <= buf_next_s;
            if (last_beat_s) begin
              cnt_r  <= {CNT_W{1'b0}};
              drop_r <= 1'b0;
              if (drop_r || in_flush) begin
                state_r <= IDLE;
              end else begin
                out_line      <= buf_next_s;
                out_line_addr <= addr_r;
                state_r       <= DONE;
              end
            end else begin
              cnt_r   <= cnt_r + CNT_W'(1);
              drop_r  <= drop_r | in_flush;
              state_r <= RESP;
            end
          end else begin
            drop_r  <= drop_r | in_flush;
            state_r <= RESP;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          drop_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_line_fill.sv
// Directed bench for bus_line_fill: a phase-level protocol model checked on
// every falling edge, plus literal expectations for the basic fill.
module tb_bus_line_fill;
  localparam int W = 64;
  localparam int T = 13;
  localparam int A = 64;
  localparam int B = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_req_valid;
  logic [A-1:0]   in_req_addr;
  logic           out_req_ready;
  logic           in_flush;
  logic           out_line_valid;
  logic [W*B-1:0] out_line;
  logic [A-1:0]   out_line_addr;
  logic           out_abtr_reqcyc;
  logic           in_abtr_grant;
  logic           out_bus_busy;
  logic           out_bus_reqcyc;
  logic [W-1:0]   out_bus_req;
  logic [T-1:0]   out_bus_reqtag;
  logic           in_bus_reqack;
  logic           in_bus_respcyc;
  logic [W-1:0]   in_bus_resp;
  logic [T-1:0]   in_bus_resptag;
  logic           out_bus_respack;

  always #5 clk = ~clk;

  bus_line_fill dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_addr(in_req_addr), .out_req_ready(out_req_ready),
    .in_flush(in_flush),
    .out_line_valid(out_line_valid), .out_line(out_line), .out_line_addr(out_line_addr),
    .out_abtr_reqcyc(out_abtr_reqcyc), .in_abtr_grant(in_abtr_grant),
    .out_bus_busy(out_bus_busy), .out_bus_reqcyc(out_bus_reqcyc),
    .out_bus_req(out_bus_req), .out_bus_reqtag(out_bus_reqtag),
    .in_bus_reqack(in_bus_reqack), .in_bus_respcyc(in_bus_respcyc),
    .in_bus_resp(in_bus_resp), .in_bus_resptag(in_bus_resptag),
    .out_bus_respack(out_bus_respack)
  );

  // What the engine must be doing this cycle, as implied by the stimulus.
  typedef enum int {P_IDLE, P_ARB, P_REQ, P_RESP, P_DONE} phase_t;
  phase_t         exp_phase = P_IDLE;
  logic [A-1:0]   exp_addr  = '0;
  logic [W*B-1:0] held_line = '0;
  logic [A-1:0]   held_addr = '0;
  int             fill_no   = -1;
  int             grant_cyc = 0;
  int             cyc       = 0;
  int             checks    = 0;
  int             passed    = 0;
  bit             chk_en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",   out_req_ready,   exp_phase == P_IDLE);
      check("abtr_reqcyc", out_abtr_reqcyc, exp_phase == P_ARB);
      check("bus_reqcyc",  out_bus_reqcyc,  exp_phase == P_REQ);
      check("bus_busy",    out_bus_busy,    exp_phase == P_REQ || exp_phase == P_RESP);
      check("respack",     out_bus_respack, exp_phase == P_RESP && in_bus_respcyc);
      check("line_valid",  out_line_valid,  exp_phase == P_DONE);
      check("out_line",    out_line,        held_line);
      check("line_addr",   out_line_addr,   held_addr);
      if (exp_phase == P_REQ) begin
        check("bus_req",    out_bus_req,    exp_addr);
        check("bus_reqtag", out_bus_reqtag, 13'h1100);
        if (fill_no == 0) check("lit_bus_req", out_bus_req, 64'h1040);
      end
      if (exp_phase == P_DONE && fill_no == 0) begin
        check("lit_line_addr", out_line_addr, 64'h1040);
        check("lit_beat5",     out_line[64*5 +: 64], 64'h5);
        check("lit_beat7",     out_line[64*7 +: 64], 64'h7);
        check("lit_latency",   cyc - grant_cyc, 10);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] beat_of(input int seed, input int i);
    return (64'(seed) << 32) | 64'(i);
  endfunction

  // One fill: grant after gdly cycles, reqack after adly, optional gap
  // between beats, flush with beat flush_at, reset with beat reset_at.
  task automatic do_fill(input logic [A-1:0] addr, input int seed, input int gdly,
                         input int adly, input bit gaps, input int flush_at, input int reset_at);
    logic [W*B-1:0] line;
    line = '0;
    fill_no++;
    in_req_valid = 1'b1; in_req_addr = addr; exp_phase = P_IDLE;
    tick;
    in_req_valid = 1'b0; in_req_addr = '0; exp_phase = P_ARB;
    exp_addr = addr & ~64'h3F;
    repeat (gdly) tick;
    in_abtr_grant = 1'b1; grant_cyc = cyc;
    tick;
    in_abtr_grant = 1'b0; exp_phase = P_REQ;
    repeat (adly) tick;
    in_bus_reqack = 1'b1;
    tick;
    in_bus_reqack = 1'b0; exp_phase = P_RESP;
    for (int i = 0; i < B; i++) begin
      if (gaps && i > 0) begin
        in_bus_respcyc = 1'b0; in_flush = 1'b0;
        tick;
      end
      if (i == reset_at) begin
        in_bus_respcyc = 1'b0; reset = 1'b1;
        tick;
        reset = 1'b0; exp_phase = P_IDLE; held_line = '0; held_addr = '0;
        return;
      end
      in_bus_respcyc = 1'b1; in_bus_resp = beat_of(seed, i); in_flush = (i == flush_at);
      line[64*i +: 64] = beat_of(seed, i);
      tick;
    end
    in_bus_respcyc = 1'b0; in_bus_resp = '0; in_flush = 1'b0;
    if (flush_at < 0) begin
      held_line = line; held_addr = exp_addr; exp_phase = P_DONE;
      tick;
    end
    exp_phase = P_IDLE;
  endtask

  task automatic flush_in_arb(input logic [A-1:0] addr);
    in_req_valid = 1'b1; in_req_addr = addr; exp_phase = P_IDLE;
    tick;
    in_req_valid = 1'b0; exp_phase = P_ARB;
    tick;
    in_flush = 1'b1;
    tick;
    in_flush = 1'b0; exp_phase = P_IDLE;
    repeat (2) tick;
  endtask

  initial begin
    reset = 1'b1; in_req_valid = 1'b0; in_req_addr = '0; in_flush = 1'b0;
    in_abtr_grant = 1'b0; in_bus_reqack = 1'b0; in_bus_respcyc = 1'b0;
    in_bus_resp = '0; in_bus_resptag = 13'h1100;
    tick;
    chk_en = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    do_fill(64'h1047,          0, 0, 0, 1'b0, -1, -1);
    tick;
    do_fill(64'h2000_00BF,     1, 5, 0, 1'b0, -1, -1);
    do_fill(64'hFFFF_FFFF_FFFF_FFC1, 2, 0, 3, 1'b1, -1, -1);
    do_fill(64'h3000,          3, 1, 1, 1'b0,  4, -1);
    tick;
    flush_in_arb(64'h4000);
    do_fill(64'h5008,          5, 0, 0, 1'b0, -1, -1);
    do_fill(64'h6010,          6, 2, 1, 1'b1, -1, -1);
    do_fill(64'h7000,          7, 0, 0, 1'b0, -1,  2);
    tick;
    do_fill(64'h8040,          8, 0, 0, 1'b0, -1, -1);
    repeat (2) tick;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
